ahbl_master_port: RTL and testbench

- Single-transfer AHB-Lite manager that converts a simple valid/ready request stream into AHB-Lite NONSEQ transfers.
- Lets an in-house engine (DMA, test sequencer, accelerator) drive the existing AHB-Lite subordinates, such as the timer, GPIO and config blocks.
- Address and data phases are pipelined: the next address phase overlaps the current data phase. Responses come back in order on a registered response port.

---
 rtl/ahbl_pkg.sv | 23 ++
 rtl/ahbl_master_port_if.sv | 50 +++++
 rtl/ahbl_master_port.sv | 113 +++++++++++
 tb/tb_ahbl_master_port.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_pkg.sv
// AHB-Lite encodings shared by managers and subordinates.
// Size legality helper lives here so every block agrees on it.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  function automatic logic size_legal(input logic [2:0] s);
    return s inside {HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD};
  endfunction

endpackage

// File: rtl/ahbl_master_port_if.sv
// Request/response stream plus AHB-Lite manager-side bus.
// master = the port, slave = requester/subordinate side.
interface ahbl_master_port_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [2:0]        req_size;
  logic [31:0]       req_wdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic              HMASTLOCK;
  logic [31:0]       HWDATA;
  logic [31:0]       HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    input  req_valid, req_write, req_addr,
    input  req_size, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output HADDR, HTRANS, HWRITE, HSIZE,
    output HBURST, HPROT, HMASTLOCK, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output req_valid, req_write, req_addr,
    output req_size, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  HADDR, HTRANS, HWRITE, HSIZE,
    input  HBURST, HPROT, HMASTLOCK, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ahbl_master_port.sv
// Single-transfer AHB-Lite manager: valid/ready requests in,
// pipelined NONSEQ transfers out, in-order registered responses.
module ahbl_master_port
  import ahbl_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011,
  parameter int         ADDR_W    = 32
) (
  input  logic HCLK,
  input  logic HRESETn,
  ahbl_master_port_if.master bus
);

  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic              a_write;
  logic [2:0]        a_size;
  logic [31:0]       a_wdata;

  logic              d_valid;
  logic              d_write;
  logic [31:0]       d_wdata;

  logic              rsp_valid;
  logic              rsp_err;
  logic [31:0]       rsp_rdata;

  logic              accept;
  logic              done;

  // A free address slot may be refilled even while HREADY is low.
  assign bus.req_ready = !a_valid | bus.HREADY;
  assign accept = bus.req_valid & bus.req_ready;
  assign done   = bus.HREADY & d_valid;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      a_valid <= 1'b0;
      a_addr  <= '0;
      a_write <= 1'b0;
      a_size  <= '0;
      a_wdata <= '0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_addr  <= bus.req_addr;
      a_write <= bus.req_write;
      a_size  <= bus.req_size;
      a_wdata <= bus.req_wdata;
    end else if (bus.HREADY) begin
      a_valid <= 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      d_valid <= 1'b0;
      d_write <= 1'b0;
      d_wdata <= '0;
    end else if (bus.HREADY) begin
      d_valid <= a_valid;
      d_write <= a_write;
      d_wdata <= a_wdata;
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= done;
      if (done) begin
        rsp_err   <= (bus.HRESP == HRESP_ERROR);
        rsp_rdata <= d_write ? '0 : bus.HRDATA;
      end
    end
  end

  assign bus.HADDR     = a_addr;
  assign bus.HWRITE    = a_write;
  assign bus.HSIZE     = a_size;
  assign bus.HTRANS    = a_valid ? HTRANS_NONSEQ
                                 : HTRANS_IDLE;
  assign bus.HWDATA    = d_wdata;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HMASTLOCK = 1'b0;

  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_err   = rsp_err;
  assign bus.rsp_rdata = rsp_rdata;

  a_stable: assert property (
    @(posedge HCLK) disable iff (!HRESETn)
    (a_valid && !bus.HREADY) |=>
      (a_valid && $stable(a_addr) &&
       $stable(a_write) && $stable(a_size)));

  wdata_stable: assert property (
    @(posedge HCLK) disable iff (!HRESETn)
    (d_valid && !bus.HREADY) |=> $stable(d_wdata));

  trans_legal: assert property (
    @(posedge HCLK) disable iff (!HRESETn)
    (bus.HTRANS != HTRANS_BUSY) &&
    (bus.HTRANS != HTRANS_SEQ));

  req_size_ok: assert property (
    @(posedge HCLK) disable iff (!HRESETn)
    accept |-> size_legal(bus.req_size));

endmodule

// File: tb/tb_ahbl_master_port.sv
// Randomized bench for ahbl_master_port: subordinate memory model
// on the bus, request queue + reference memory as the golden model.
module tb_ahbl_master_port;
  import ahbl_pkg::*;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;

  ahbl_master_port_if bus ();

  ahbl_master_port #(
    .HPROT_VAL (4'b0011),
    .ADDR_W    (32)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  always #5 HCLK = ~HCLK;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h",
                  tag, got, exp);
  endtask

  // reference model state
  req_t stim[$];
  req_t exp_adr[$];
  rsp_t exp_rsp[$];
  bit [31:0] rmem [bit [31:0]];
  bit [31:0] bmem [bit [31:0]];
  int waitq[$];
  bit rnd_valid = 0;
  bit rnd_wait = 0;
  int n_rsp = 0;

  // subordinate data-phase state
  bit        dp_v = 0;
  bit [31:0] dp_a;
  bit        dp_wr;
  bit [31:0] dp_wd;
  bit        dp_e;
  bit        dp_e1;
  int        dp_w;

  // per-cycle logs, index = cycle number
  int cyc = 0;
  int acc_log[$];
  logic [31:0] lg_trans[$], lg_addr[$], lg_size[$];
  logic [31:0] lg_wdata[$], lg_rdata[$];
  logic        lg_rspv[$], lg_err[$], lg_rdy[$];

  function automatic bit is_err(input logic [31:0] a);
    return (a[31:28] == 4'hE) || (a == 32'h0000_000F);
  endfunction

  function automatic bit [31:0] key(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic bit [31:0] brd(input bit [31:0] k);
    return bmem.exists(k) ? bmem[k] : 32'h0;
  endfunction

  function automatic bit [31:0] rrd(input bit [31:0] k);
    return rmem.exists(k) ? rmem[k] : 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a,
                         input logic [31:0] d);
    bmem[key(a)] = d;
    rmem[key(a)] = d;
  endtask

  task automatic model_accept();
    req_t r;
    rsp_t e;
    r.wr    = bus.req_write;
    r.addr  = bus.req_addr;
    r.size  = bus.req_size;
    r.wdata = bus.req_wdata;
    exp_adr.push_back(r);
    e.err = is_err(r.addr);
    e.rdata = 32'h0;
    if (r.wr && !e.err) rmem[key(r.addr)] = r.wdata;
    if (!r.wr && !e.err) e.rdata = rrd(key(r.addr));
    exp_rsp.push_back(e);
  endtask

  task automatic bus_step();
    req_t x;
    bus.HREADY = 1'b1;
    bus.HRESP  = HRESP_OKAY;
    bus.HRDATA = 32'h0;
    if (dp_v) begin
      if (dp_w > 0) begin
        bus.HREADY = 1'b0;
        dp_w--;
      end else if (dp_e && !dp_e1) begin
        bus.HREADY = 1'b0;
        bus.HRESP  = HRESP_ERROR;
        dp_e1 = 1;
      end else begin
        bus.HRESP = dp_e;
        if (dp_wr) begin
          check("hwdata", bus.HWDATA, dp_wd);
          if (!dp_e) bmem[key(dp_a)] = bus.HWDATA;
        end else if (!dp_e) begin
          bus.HRDATA = brd(key(dp_a));
        end
        dp_v = 0;
      end
    end
    if (bus.HREADY && bus.HTRANS == HTRANS_NONSEQ) begin
      if (exp_adr.size() == 0) begin
        check("addr_extra", {30'h0, bus.HTRANS}, 32'h0);
      end else begin
        x = exp_adr.pop_front();
        check("haddr", bus.HADDR, x.addr);
        check("hwrite", {31'h0, bus.HWRITE}, {31'h0, x.wr});
        check("hsize", {29'h0, bus.HSIZE}, {29'h0, x.size});
        dp_wd = x.wdata;
      end
      dp_v  = 1;
      dp_a  = bus.HADDR;
      dp_wr = bus.HWRITE;
      dp_e  = is_err(bus.HADDR);
      dp_e1 = 0;
      if (waitq.size() > 0) dp_w = waitq.pop_front();
      else if (rnd_wait && $urandom_range(3) == 0)
        dp_w = $urandom_range(3, 1);
      else dp_w = 0;
    end
  endtask

  task automatic drive_req();
    req_t r;
    if (HRESETn && !bus.req_valid && stim.size() > 0 &&
        (!rnd_valid || $urandom_range(9) < 7)) begin
      r = stim.pop_front();
      bus.req_valid = 1'b1;
      bus.req_write = r.wr;
      bus.req_addr  = r.addr;
      bus.req_size  = r.size;
      bus.req_wdata = r.wdata;
    end
  endtask

  task automatic cycle();
    bit acc;
    rsp_t e;
    @(negedge HCLK);
    bus_step();
    drive_req();
    #1;
    lg_rdy.push_back(bus.req_ready);
    acc = HRESETn && bus.req_valid && bus.req_ready;
    if (acc) begin
      model_accept();
      acc_log.push_back(cyc);
    end
    @(posedge HCLK);
    #1;
    if (acc) bus.req_valid = 1'b0;
    if (!HRESETn) begin
      dp_v = 0;
      exp_adr.delete();
      exp_rsp.delete();
    end
    lg_trans.push_back({30'h0, bus.HTRANS});
    lg_addr.push_back(bus.HADDR);
    lg_size.push_back({29'h0, bus.HSIZE});
    lg_wdata.push_back(bus.HWDATA);
    lg_rdata.push_back(bus.rsp_rdata);
    lg_rspv.push_back(bus.rsp_valid);
    lg_err.push_back(bus.rsp_err);
    if (bus.rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        check("rsp_extra", {31'h0, bus.rsp_valid}, 32'h0);
      end else begin
        e = exp_rsp.pop_front();
        check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
        check("rsp_rdata", bus.rsp_rdata, e.rdata);
        n_rsp++;
      end
    end
    cyc++;
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    while ((stim.size() > 0 || bus.req_valid ||
            exp_rsp.size() > 0) && k < budget) begin
      cycle();
      k++;
    end
    check("idle_timeout",
          stim.size() + exp_rsp.size(), 32'h0);
    cycle();
    cycle();
  endtask

  function automatic req_t mk(input logic wr,
                              input logic [31:0] a,
                              input logic [2:0] s,
                              input logic [31:0] d);
    req_t r;
    r.wr = wr;
    r.addr = a;
    r.size = s;
    r.wdata = d;
    return r;
  endfunction

  initial begin
    int a, b, base, r0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_size  = '0;
    bus.req_wdata = '0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;
    bus.HRDATA    = '0;

    // reset state
    HRESETn = 1'b0;
    cycle();
    cycle();
    check("rst_htrans", lg_trans[cyc-1], {30'h0, HTRANS_IDLE});
    check("rst_rspv", {31'h0, lg_rspv[cyc-1]}, 32'h0);
    check("rst_rdata", lg_rdata[cyc-1], 32'h0);
    check("rst_haddr", lg_addr[cyc-1], 32'h0);
    check("rst_hwdata", lg_wdata[cyc-1], 32'h0);
    check("rst_hprot", {28'h0, bus.HPROT}, 32'h3);
    HRESETn = 1'b1;
    cycle();

    // 1: single write
    base = acc_log.size();
    stim.push_back(mk(1, 32'h4000_0008, HSIZE_WORD, 32'h1234));
    run_until_idle(20);
    a = acc_log[base];
    check("t1_nonseq", lg_trans[a], {30'h0, HTRANS_NONSEQ});
    check("t1_idle", lg_trans[a+1], {30'h0, HTRANS_IDLE});
    check("t1_hwdata", lg_wdata[a+1], 32'h1234);
    check("t1_rsp_early", {31'h0, lg_rspv[a+1]}, 32'h0);
    check("t1_rsp", {31'h0, lg_rspv[a+2]}, 32'h1);

    // 2: back-to-back reads
    preload(32'h00, 32'hA0);
    preload(32'h04, 32'hA4);
    preload(32'h08, 32'hA8);
    base = acc_log.size();
    for (int i = 0; i < 3; i++)
      stim.push_back(mk(0, 32'(4 * i), HSIZE_WORD, 32'h0));
    run_until_idle(20);
    a = acc_log[base];
    check("t2_b2b", 32'(acc_log[base+2] - a), 32'h2);
    for (int i = 0; i < 3; i++) begin
      check("t2_nonseq", lg_trans[a+i], {30'h0, HTRANS_NONSEQ});
      check("t2_rspv", {31'h0, lg_rspv[a+2+i]}, 32'h1);
      check("t2_rdata", lg_rdata[a+2+i], 32'hA0 + 32'(4 * i));
    end

    // 3: read with two wait states, queued write behind it
    preload(32'h20, 32'h77);
    waitq.push_back(2);
    base = acc_log.size();
    stim.push_back(mk(0, 32'h20, HSIZE_WORD, 32'h0));
    stim.push_back(mk(1, 32'h24, HSIZE_HALF, 32'hBEEF));
    run_until_idle(20);
    a = acc_log[base];
    check("t3_wr_acc", 32'(acc_log[base+1] - a), 32'h1);
    for (int i = 1; i <= 3; i++) begin
      check("t3_trans", lg_trans[a+i], {30'h0, HTRANS_NONSEQ});
      check("t3_haddr", lg_addr[a+i], 32'h24);
      check("t3_hsize", lg_size[a+i], {29'h0, HSIZE_HALF});
    end
    check("t3_rdy_w1", {31'h0, lg_rdy[a+2]}, 32'h0);
    check("t3_rdy_w2", {31'h0, lg_rdy[a+3]}, 32'h0);
    check("t3_rsp_w", {31'h0, lg_rspv[a+3]}, 32'h0);
    check("t3_rsp", {31'h0, lg_rspv[a+4]}, 32'h1);
    check("t3_rdata", lg_rdata[a+4], 32'h77);

    // 4: error write then queued read
    preload(32'h10, 32'h5A5A);
    base = acc_log.size();
    stim.push_back(mk(1, 32'h0F, HSIZE_BYTE, 32'hFF));
    stim.push_back(mk(0, 32'h10, HSIZE_WORD, 32'h0));
    run_until_idle(20);
    a = acc_log[base];
    check("t4_rdy_err", {31'h0, lg_rdy[a+2]}, 32'h0);
    check("t4_wr_rsp", {31'h0, lg_rspv[a+3]}, 32'h1);
    check("t4_wr_err", {31'h0, lg_err[a+3]}, 32'h1);
    check("t4_rd_rsp", {31'h0, lg_rspv[a+4]}, 32'h1);
    check("t4_rd_err", {31'h0, lg_err[a+4]}, 32'h0);
    check("t4_rd_data", lg_rdata[a+4], 32'h5A5A);

    // 5: reset during data phase
    base = acc_log.size();
    r0 = n_rsp;
    stim.push_back(mk(0, 32'h30, HSIZE_WORD, 32'h0));
    b = 0;
    while (acc_log.size() == base && b < 5) begin
      cycle();
      b++;
    end
    check("t5_acc", 32'(acc_log.size() - base), 32'h1);
    cycle();
    HRESETn = 1'b0;
    cycle();
    HRESETn = 1'b1;
    check("t5_idle", lg_trans[cyc-1], {30'h0, HTRANS_IDLE});
    check("t5_norsp", {31'h0, lg_rspv[cyc-1]}, 32'h0);
    cycle();
    check("t5_norsp2", {31'h0, lg_rspv[cyc-1]}, 32'h0);
    check("t5_cnt", 32'(n_rsp - r0), 32'h0);
    stim.push_back(mk(1, 32'h34, HSIZE_WORD, 32'h99));
    stim.push_back(mk(0, 32'h34, HSIZE_WORD, 32'h0));
    run_until_idle(20);
    check("t5_after", 32'(n_rsp - r0), 32'h2);

    // 6: random traffic against the memory model
    rnd_valid = 1;
    rnd_wait = 1;
    r0 = n_rsp;
    for (int i = 0; i < 1000; i++) begin
      req_t r;
      r.wr   = 1'($urandom_range(1));
      r.addr = (($urandom_range(15) == 0) ? 32'hE000_0000 : 32'h0)
             | 32'($urandom_range(63) << 2);
      r.size = 3'($urandom_range(2));
      r.wdata = $urandom;
      stim.push_back(r);
    end
    run_until_idle(20000);
    check("t6_count", 32'(n_rsp - r0), 32'd1000);
    check("t6_addr_left", 32'(exp_adr.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
